// File: rtl/sig_field_pkg.sv
// Shared types and constants for the 802.11a SIGNAL field generator.
// Optional length check is enabled with SIG_FIELD_LEN_CHECK_EN.
package sig_field_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_e;

  localparam int SIG_BITS = 24;
  localparam int MAX_LEN  = 4095;
  localparam int CNT_W    = $clog2(SIG_BITS);
  localparam int LEN_W    = 12;

  localparam int RATE_LSB   = 0;
  localparam int RSVD_POS   = 4;
  localparam int LEN_LSB    = 5;
  localparam int PARITY_POS = 17;
  localparam int TAIL_LSB   = 18;

  // R1 sits in bit 0 so it is transmitted first.
  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  function automatic logic [SIG_BITS-1:0] build_word(
    input logic [3:0]       rate,
    input logic [LEN_W-1:0] len
  );
    logic [SIG_BITS-1:0] w;
    w = '0;
    w[RATE_LSB +: 4]     = rate;
    w[RSVD_POS]          = 1'b0;
    w[LEN_LSB +: LEN_W]  = len;
    w[PARITY_POS]        = ^w[PARITY_POS-1:0];
    w[TAIL_LSB +: 6]     = 6'd0;
    return w;
  endfunction

endpackage

// File: rtl/sig_field_gen_rate_lut.sv
// Maps the frame_type rate index to its RATE code.
// Indices above 7 are flagged as illegal.
module sig_rate_lut
  import sig_field_pkg::*;
(
  input  logic [3:0] frame_type_i,
  output logic [3:0] rate_code_o,
  output logic       type_ok_o
);

  always_comb begin
    rate_code_o = 4'd0;
    type_ok_o   = 1'b1;
    unique case (frame_type_i)
      4'd0:    rate_code_o = RATE_6M;
      4'd1:    rate_code_o = RATE_9M;
      4'd2:    rate_code_o = RATE_12M;
      4'd3:    rate_code_o = RATE_18M;
      4'd4:    rate_code_o = RATE_24M;
      4'd5:    rate_code_o = RATE_36M;
      4'd6:    rate_code_o = RATE_48M;
      4'd7:    rate_code_o = RATE_54M;
      default: type_ok_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/sig_field_gen.sv
// SIGNAL field builder and serialiser for the OFDM TX chain.
// Define SIG_FIELD_LEN_CHECK_EN to reject zero or oversize lengths.
module sig_field_gen
  import sig_field_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vld,
  input  logic [15:0] frame_len,
  input  logic [3:0]  frame_type,
  output logic        sig_bit,
  output logic        sig_vld,
  input  logic        sig_rdy,
  output logic        busy,
  output logic        sig_done,
  output logic        desc_drop,
  output logic        desc_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIG_BITS - 1);

  state_e              state_q, state_d;
  logic [3:0]          rate_q, rate_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SIG_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;

  logic [3:0] lut_rate;
  logic       type_ok;
  logic       len_ok;
  logic       xfer;

  sig_rate_lut u_lut (
    .frame_type_i (frame_type),
    .rate_code_o  (lut_rate),
    .type_ok_o    (type_ok)
  );

`ifdef SIG_FIELD_LEN_CHECK_EN
  assign len_ok = (frame_len != 16'd0) &&
                  (frame_len <= 16'(MAX_LEN));
`else
  assign len_ok = 1'b1;
`endif

  assign xfer = vld_q & sig_rdy;

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    len_d   = len_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_vld) begin
          if (type_ok && len_ok) begin
            rate_d  = lut_rate;
            len_d   = frame_len[LEN_W-1:0];
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        drop_d  = frame_vld;
        shift_d = build_word(rate_q, len_q);
        cnt_d   = '0;
        vld_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        drop_d = frame_vld;
        if (xfer) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rate_q  <= '0;
      len_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign sig_bit   = shift_q[0];
  assign sig_vld   = vld_q;
  assign busy      = busy_q;
  assign sig_done  = done_q;
  assign desc_drop = drop_q;
  assign desc_err  = err_q;

endmodule

// File: tb/tb_sig_field_gen.sv
// Scoreboard bench for sig_field_gen with a behavioural SIGNAL model.
// Compile with SIG_FIELD_LEN_CHECK_EN to match a length-checking build.
module tb_sig_field_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_vld = 1'b0;
  logic [15:0] frame_len = '0;
  logic [3:0]  frame_type = '0;
  logic        sig_bit, sig_vld, busy;
  logic        sig_rdy = 1'b1;
  logic        sig_done, desc_drop, desc_err;

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  int done_seen = 0, done_exp = 0;
  int err_seen = 0, err_exp = 0;
  int drop_seen = 0, drop_exp = 0;
  int rdy_mode = 0;
  bit prev_stall = 0;
  bit prev_bit = 0;

  sig_field_gen dut (
    .clk        (clk),
    .rst        (rst),
    .frame_vld  (frame_vld),
    .frame_len  (frame_len),
    .frame_type (frame_type),
    .sig_bit    (sig_bit),
    .sig_vld    (sig_vld),
    .sig_rdy    (sig_rdy),
    .busy       (busy),
    .sig_done   (sig_done),
    .desc_drop  (desc_drop),
    .desc_err   (desc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(int t, int len);
    bit ok;
    ok = (t < 8);
`ifdef SIG_FIELD_LEN_CHECK_EN
    if (len == 0 || len > 4095) ok = 0;
`endif
    return ok;
  endfunction

  // Rate strings as written R1..R4, R1 being the leftmost digit.
  function automatic void model_push(int t, int len);
    int rt[8] = '{13, 15, 5, 7, 9, 11, 1, 3};
    int ones = 0;
    int l12 = len % 4096;
    bit b;
    for (int i = 0; i < 4; i++) begin
      b = bit'((rt[t] >> (3 - i)) & 1);
      ones += b;
      exp_q.push_back(b);
    end
    exp_q.push_back(1'b0);
    for (int i = 0; i < 12; i++) begin
      b = bit'((l12 >> i) & 1);
      ones += b;
      exp_q.push_back(b);
    end
    exp_q.push_back(bit'(ones % 2));
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
  endfunction

  task automatic issue(int t, int len, bit busy_now);
    frame_vld  = 1'b1;
    frame_type = 4'(t);
    frame_len  = 16'(len);
    if (busy_now) drop_exp++;
    else if (legal(t, len)) begin
      model_push(t, len);
      done_exp++;
    end else err_exp++;
    @(posedge clk); #1;
    frame_vld = 1'b0;
  endtask

  task automatic send(int t, int len, bit busy_now);
    @(posedge clk); #1;
    issue(t, len, busy_now);
  endtask

  task automatic wait_done(int start, output int cyc);
    cyc = -1;
    for (int i = start; i < start + 400; i++) begin
      @(negedge clk);
      if (sig_done) begin
        cyc = i;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run_frame(int t, int len);
    int cyc;
    bit acc;
    acc = legal(t, len);
    send(t, len, 0);
    @(negedge clk);
    if (acc) begin
      chk("busy_n1", busy, 1);
      wait_done(2, cyc);
      chk("queue_drained", exp_q.size(), 0);
    end else begin
      chk("err_n1", desc_err, 1);
      @(negedge clk);
      chk("busy_after_err", busy, 0);
      chk("vld_after_err", sig_vld, 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: sig_rdy = 1'b1;
      1: sig_rdy = ~sig_rdy;
      default: sig_rdy = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall)
        chk("stall_hold", {sig_vld, sig_bit}, {1'b1, prev_bit});
      if (sig_vld && sig_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("sig_bit", sig_bit, exp_q.pop_front());
      end
      prev_stall = sig_vld && !sig_rdy;
      prev_bit = sig_bit;
      if (sig_done) done_seen++;
      if (desc_err) err_seen++;
      if (desc_drop) drop_seen++;
    end
  end

  initial begin
    int cyc;
    bit hit;
    #1;
    chk("rst_outs", {sig_bit, sig_vld, busy, sig_done, desc_drop, desc_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic field, full-rate ready, exact latencies.
    send(0, 10, 0);
    @(negedge clk);
    chk("t1_busy_n1", busy, 1);
    chk("t1_vld_n1", sig_vld, 0);
    @(negedge clk);
    chk("t1_vld_n2", sig_vld, 1);
    chk("t1_bit0_n2", sig_bit, 1);
    wait_done(3, cyc);
    chk("t1_done_lat", cyc, 26);
    @(negedge clk);
    chk("t1_idle", {busy, sig_vld, sig_done}, 0);

    // Toggling ready.
    rdy_mode = 1;
    run_frame(7, 100);
    rdy_mode = 0;

    // Drop while sending, then accept in the sig_done cycle.
    send(0, 10, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (exp_q.size() <= 19) hit = 1;
    end
    #1;
    issue(3, 50, 1);
    @(negedge clk);
    chk("t3_drop", desc_drop, 1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (sig_done) hit = 1;
    end
    chk("t3_done_seen", hit, 1);
    issue(5, 777, 0);
    @(negedge clk);
    chk("t3_busy_n1", busy, 1);
    chk("t3_vld_n1", sig_vld, 0);
    @(negedge clk);
    chk("t3_vld_n2", sig_vld, 1);
    wait_done(3, cyc);
    chk("t3_done_lat", cyc, 26);

    // Illegal type and length boundaries.
    run_frame(9, 10);
    run_frame(0, 4096);
    run_frame(0, 0);
    run_frame(2, 4095);

    // Reset in the middle of a field.
    send(1, 200, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      if (exp_q.size() <= 12) hit = 1;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outs",
        {sig_bit, sig_vld, busy, sig_done, desc_drop, desc_err}, 0);
    exp_q.delete();
    done_exp--;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", sig_done, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    run_frame(4, 1500);

    // Random descriptors under random back-pressure.
    rdy_mode = 2;
    for (int n = 0; n < 12; n++) begin
      int t, len;
      t = int'($urandom_range(0, 9));
      len = int'($urandom_range(0, 4200));
      run_frame(t, len);
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    chk("done_count", done_seen, done_exp);
    chk("err_count", err_seen, err_exp);
    chk("drop_count", drop_seen, drop_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig_field_gen.md
Name: sig_field_gen

Overview:
- Downstream consumer of the fake-MAC frame descriptor (frame_vld, frame_len, frame_type) in the OFDM TX chain.
- Builds the 24-bit 802.11a SIGNAL field: RATE(4), reserved(1), LENGTH(12), even parity(1), tail(6).
- Serialises the field bit-by-bit to the convolutional encoder stage under a valid/ready handshake.
- Reports busy and completion so the payload path can sequence after SIGNAL.

Parameters:
- SIG_BITS, 24, SIGNAL field length in bits; fixed, used for counter width and terminal count.
- MAX_LEN, 4095, largest legal LENGTH value in octets.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_vld  in  1  single-cycle frame descriptor strobe
- frame_len  in  16  PSDU length in octets
- frame_type  in  4  rate index 0..7 (6,9,12,18,24,36,48,54 Mbps)
- sig_bit  out  1  serial SIGNAL bit
- sig_vld  out  1  sig_bit valid
- sig_rdy  in  1  downstream ready; bit transfers when sig_vld & sig_rdy
- busy  out  1  descriptor latched, field not yet fully sent
- sig_done  out  1  one-cycle pulse after last bit transferred
- desc_drop  out  1  one-cycle pulse when frame_vld arrives while busy
- desc_err  out  1  one-cycle pulse when a descriptor is rejected

Behaviour:
- Reset values: sig_bit=0, sig_vld=0, busy=0, sig_done=0, desc_drop=0, desc_err=0, FSM=IDLE, bit counter=0, shift register=0.
- FSM states: IDLE, LOAD, SEND.
- IDLE: on frame_vld, latch frame_len and frame_type, busy=1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): build the 24-bit word, compute parity, go to SEND with sig_vld=1.
- Latency: frame_vld in cycle N gives sig_vld=1 in cycle N+2, carrying bit 0.
- Word bit order, transmitted bit 0 first:
  - bits 0-3: RATE R1..R4.
  - bit 4: 0.
  - bits 5-16: LENGTH, LSB first.
  - bit 17: even parity over bits 0-16.
  - bits 18-23: 0.
- RATE codes R1..R4 by frame_type: 0=1101, 1=1111, 2=0101, 3=0111, 4=1001, 5=1011, 6=0001, 7=0011.
- frame_type 8..15: descriptor rejected (desc_err pulse in cycle N+1), return to IDLE, nothing sent.
- SEND:
  - On each sig_vld & sig_rdy: shift the register and increment the 5-bit counter.
  - sig_bit and sig_vld hold stable while sig_rdy=0.
  - sig_vld never deasserts mid-field.
  - On the transfer of bit 23: next cycle sig_vld=0, busy=0, sig_done=1 for one cycle, FSM=IDLE.
- frame_vld while busy (LOAD or SEND): descriptor ignored, desc_drop pulses next cycle, current field unaffected.
- frame_vld in the same cycle that sig_done is asserted: accepted normally, because the FSM is already IDLE.
- rst mid-field: immediate abort. All outputs go to reset values and no sig_done is generated.
- LENGTH is frame_len[11:0] after any check.

Optional Feature:
- Macro SIG_FIELD_LEN_CHECK_EN.
- Defined: frame_len==0 or frame_len>MAX_LEN rejects the descriptor. desc_err pulses in cycle N+1, FSM returns to IDLE, no bits sent.
- Not defined: no length check. LENGTH is the truncated frame_len[11:0]. desc_err flags only illegal frame_type.

Decomposition:
- Shared package / header sig_field_pkg:
  - FSM state encodings.
  - SIG_BITS and MAX_LEN.
  - RATE code constants, RATE_6M..RATE_54M.
  - Bit-position constants: RATE_LSB=0, RSVD_POS=4, LEN_LSB=5, PARITY_POS=17, TAIL_LSB=18.
- Sub-module sig_rate_lut: combinational frame_type to {rate_code[3:0], type_ok}, instantiated once.

Test Plan:
- type=0, len=10, sig_rdy=1 -> bits 1,1,0,1,0, then 0,1,0,1,0,0,0,0,0,0,0,0, parity 1, six 0s. sig_vld at N+2, sig_done at N+26.
- type=7, len=100, sig_rdy toggled 1/0 every cycle -> RATE 0,0,1,1. LENGTH 100 LSB-first. Parity 1. sig_bit stable during each stall. 24 transfers total, sig_done once.
- frame_vld during SEND (at bit 5) -> desc_drop pulse, first field continues unchanged. Second frame_vld in the sig_done cycle -> accepted, new field starts 2 cycles later.
- type=9, len=10 -> desc_err pulse at N+1, busy=0 by N+2, sig_vld never asserted.
- With SIG_FIELD_LEN_CHECK_EN, len=0 and len=4096 -> desc_err each, nothing sent. Without the macro, len=4096 -> LENGTH=0, parity=1 (type 0), field sent.
- Assert rst at bit 12 -> all outputs 0 within the same cycle, no sig_done. Next frame_vld after release -> full clean 24-bit field.
